// File: rtl/inject_sched_if.sv
// inject_sched_if: local-source enqueue and two-channel ring injection signals
interface inject_sched_if #(parameter int DEPTH = 4, parameter int W = 8) ();
  localparam int OW = $clog2(DEPTH) + 1;
  logic [W-1:0] enq_flit;
  logic enq_valid;
  logic enq_ready;
  logic c0_busy;
  logic c1_busy;
  logic [W-1:0] c_in0;
  logic [W-1:0] c_in1;
  logic ack0;
  logic ack1;
  logic starve;
  logic [OW-1:0] occupancy;
  modport master (
    output enq_flit, enq_valid, c0_busy, c1_busy, ack0, ack1,
    input enq_ready, c_in0, c_in1, starve, occupancy
  );
  modport slave (
    input enq_flit, enq_valid, c0_busy, c1_busy, ack0, ack1,
    output enq_ready, c_in0, c_in1, starve, occupancy
  );
endinterface

// File: rtl/inject_sched.sv
// inject_sched: FIFO-buffered injection of local flits onto whichever ring channel has a free slot
module inject_sched #(
  parameter int DEPTH = 4,
  parameter int STARVE_MAX = 16,
  parameter int STEER_W = 8,
  parameter int VALID_F = STEER_W - 1
) (
  input logic clk,
  input logic rst_n,
  inject_sched_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [STEER_W-1:0] VBIT = STEER_W'(1) << VALID_F;
  localparam logic [7:0] SMAX = 8'(STARVE_MAX);
  typedef enum logic [1:0] {IDLE, OFFER, STARVE} state_t;
  state_t state, state_nx;
  logic [STEER_W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] cnt, cnt_nx;
  logic [7:0] wait_cnt, wait_nx;
  logic pref, nonempty, off0, off1, push, pop;
  always_comb begin
    nonempty = cnt != '0;
    off0 = nonempty & ~bus.c0_busy & (bus.c1_busy | ~pref);
    off1 = nonempty & ~bus.c1_busy & (bus.c0_busy | pref);
    push = bus.enq_valid & (cnt < (AW+1)'(DEPTH));
    // an ack on a channel not offered, or on both, is ignored
    pop = (bus.ack0 & off0 & ~bus.ack1) | (bus.ack1 & off1 & ~bus.ack0);
    cnt_nx = cnt + (AW+1)'(push) - (AW+1)'(pop);
    wait_nx = (pop | ~nonempty) ? 8'd0 : (wait_cnt == SMAX) ? wait_cnt : wait_cnt + 8'd1;
    state_nx = (cnt_nx == '0) ? IDLE : (wait_nx == SMAX) ? STARVE : OFFER;
  end
  assign bus.enq_ready = cnt < (AW+1)'(DEPTH);
  assign bus.c_in0 = off0 ? mem[rd_ptr] : '0;
  assign bus.c_in1 = off1 ? mem[rd_ptr] : '0;
  assign bus.starve = state == STARVE;
  assign bus.occupancy = cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
      wait_cnt <= '0;
      pref <= 1'b0;
    end else begin
      state <= state_nx;
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      cnt <= cnt_nx;
      wait_cnt <= wait_nx;
      pref <= pop ? bus.ack0 : pref;
    end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= bus.enq_flit | VBIT;
endmodule

// File: doc/inject_sched.md
# inject_sched

Injection scheduler for an RC ring node. Buffers locally generated flits in a small FIFO and offers the head flit to exactly one of the two ring channels (c0/c1) per cycle, choosing whichever channel has an empty slot. It sits between the node's local source and the two-channel injector, consuming the injector's per-channel acks. It also flags injection starvation when the head flit has waited too long for a free slot.

## Interface
- DEPTH, 4: FIFO entries; power of 2, ≥2.
- STARVE_MAX, 16: wait-cycle count at which `starve` asserts; ≥1, ≤255.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enq_flit  in  `steer_w`  flit from local source; valid bit at `valid_f`.
- enq_valid  in  1  enqueue request.
- enq_ready  out  1  FIFO can accept; enqueue occurs when enq_valid & enq_ready.
- c0_busy  in  1  ring slot occupancy of channel 0 (c0[`valid_f`]).
- c1_busy  in  1  ring slot occupancy of channel 1 (c1[`valid_f`]).
- c_in0  out  `steer_w`  flit offered to channel 0; all-zero when not offered.
- c_in1  out  `steer_w`  flit offered to channel 1; all-zero when not offered.
- ack0  in  1  injector accepted c_in0 this cycle.
- ack1  in  1  injector accepted c_in1 this cycle.
- starve  out  1  head flit starved.
- occupancy  out  clog2(DEPTH)+1  current FIFO entry count.

## Operation
- FIFO: rd/wr pointers clog2(DEPTH) bits, wrap modulo DEPTH; count 0..DEPTH. enq_ready = (count < DEPTH); no bypass of a full FIFO by a same-cycle pop. Enqueue stores enq_flit with `valid_f` forced to 1.
- Channel select (combinational, from registered state and c*_busy): if count==0, offer nothing. Else if exactly one channel free, offer head on that channel. If both free, offer on channel `pref`. If both busy, offer nothing. Head flit never presented on both c_in0 and c_in1 in the same cycle.
- pop = ack0 | ack1. ack on a channel not offered this cycle, or ack0 & ack1, is a protocol error; block ignores the illegal ack (no pop) and bench flags it.
- pref (1 bit, reset 0): after a pop via channel k, pref <= ~k. Unchanged otherwise.
- Simultaneous enqueue and pop: count unchanged, both pointers advance.
- FSM, 2-bit state:
  - IDLE: count==0. Enqueue → OFFER.
  - OFFER: head present, wait_cnt counting. Pop leaving FIFO empty and no enqueue → IDLE. wait_cnt reaching STARVE_MAX → STARVE.
  - STARVE: starve=1. Pop → OFFER (or IDLE if empty after pop/enq).
- wait_cnt (8 bits, saturating at STARVE_MAX): clears on pop or when empty. Increments each cycle the FIFO is non-empty and no pop occurs. starve = (state==STARVE), i.e. wait_cnt==STARVE_MAX registered.

## Timing
- Reset values: enq_ready=1, c_in0=c_in1=0, starve=0, occupancy=0, pref=0, state=IDLE, wait_cnt=0. Reset is asynchronous mid-operation: FIFO contents discarded, outputs return to reset values immediately.
- Enqueue-to-offer latency: 1 cycle. A flit enqueued at edge N is visible on c_in* during cycle N+1.
- Offer/ack: same-cycle combinational. The ack sampled at edge M pops the head, and the next head is offered in cycle M+1.
- Throughput: 1 flit/cycle sustained when a slot is free every cycle.
- starve asserts in the cycle after the STARVE_MAX-th consecutive non-popped non-empty cycle. It deasserts in the cycle after the pop.
- occupancy is registered and updates on the edge of enq/pop.

## Test plan
- Reset then enqueue A (c0_busy=c1_busy=0), ack0 in offer cycle → c_in0=A with valid set one cycle after enq, c_in1=0. After ack0, occupancy=0 and pref=1. Next flit B offered on c_in1.
- c0_busy=1, c1_busy=0, FIFO holds A,B, ack1 each offer → A then B appear on c_in1 in consecutive cycles. c_in0 stays 0 throughout.
- Fill 4 flits with no acks → enq_ready=0 at occupancy=4. Then do simultaneous enq_valid plus an ack: the enqueue is refused, and occupancy goes 4→3.
- Both busy for 16 cycles with 1 flit queued (STARVE_MAX=16) → starve=1 on cycle 17. Free c1 and ack1 → starve=0 the next cycle, and wait_cnt=0.
- Occupancy 2, enq and ack0 in the same cycle → occupancy stays 2 and FIFO order is preserved across pointer wrap (≥DEPTH+1 flits pushed through).
- Assert rst_n low mid-stream with 3 flits queued and starve=1 → all outputs at reset values immediately. After release, no stale flit is offered.
